// File: rtl/avalon_st_if.sv
// Avalon-ST style message channel: data beat with sop/eop/empty framing and ready/valid flow control.
interface avalon_st_if #(
    parameter int DATA_WIDTH_IN_BYTES = 16
);
    localparam int EMPTY_W = $clog2(DATA_WIDTH_IN_BYTES);

    logic [DATA_WIDTH_IN_BYTES*8-1:0] data;
    logic                             valid;
    logic                             rdy;
    logic                             sop;
    logic                             eop;
    logic [EMPTY_W-1:0]               empty;

    modport master (
        output data, valid, sop, eop, empty,
        input  rdy
    );

    modport slave (
        input  data, valid, sop, eop, empty,
        output rdy
    );
endinterface

// File: rtl/avalon_st_packetizer.sv
// Frames an unframed word stream into an Avalon-ST message sized by a byte-length command.
// Optional macro AVALON_PACKETIZER_B2B_EN lets the next command be taken on the eop beat (no idle gap).
module avalon_st_packetizer #(
    parameter int DATA_WIDTH_IN_BYTES = 16,
    parameter int MAX_MSG_LEN_BYTES   = 4096,
    parameter int G_RST_POLARITY      = 0,
    localparam int EMPTY_W            = $clog2(DATA_WIDTH_IN_BYTES),
    localparam int LEN_W              = $clog2(MAX_MSG_LEN_BYTES + 1)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             cmd_valid,
    input  logic [LEN_W-1:0]                 cmd_len,
    output logic                             cmd_rdy,
    input  logic                             raw_valid,
    input  logic [DATA_WIDTH_IN_BYTES*8-1:0] raw_data,
    output logic                             raw_rdy,
    avalon_st_if.master                      msg_out,
    output logic                             busy,
    output logic                             len_error
);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t             r_state;
    logic [LEN_W-1:0]   r_remaining;
    logic               r_first;
    logic               r_len_error;

    logic                             w_send;
    logic                             w_drive;
    logic                             w_eop;
    logic                             w_xfer;
    logic                             w_cmd_hs;
    logic                             w_cmd_legal;
    logic [EMPTY_W-1:0]               w_empty;
    logic [DATA_WIDTH_IN_BYTES*8-1:0] w_data;

    assign w_send      = (r_state == SEND);
    assign w_drive     = w_send & raw_valid;
    assign w_eop       = (r_remaining <= LEN_W'(DATA_WIDTH_IN_BYTES));
    assign w_xfer      = w_drive & msg_out.rdy;
    assign w_cmd_legal = (cmd_len >= LEN_W'(1)) && (cmd_len <= LEN_W'(MAX_MSG_LEN_BYTES));
    assign w_cmd_hs    = cmd_valid & cmd_rdy;

    // Only the low bits of remaining matter on the last beat, where remaining <= beat width.
    assign w_empty = w_eop ? (EMPTY_W'(DATA_WIDTH_IN_BYTES) - r_remaining[EMPTY_W-1:0]) : '0;

`ifdef AVALON_PACKETIZER_B2B_EN
    assign cmd_rdy = ~w_send | (w_xfer & w_eop);
`else
    assign cmd_rdy = ~w_send;
`endif

    // Unused bytes of the final beat sit at the low byte lanes.
    for (genvar gi = 0; gi < DATA_WIDTH_IN_BYTES; gi++) begin : g_byte
        assign w_data[gi*8 +: 8] = (w_empty > EMPTY_W'(gi)) ? 8'h00 : raw_data[gi*8 +: 8];
    end

    assign msg_out.valid = w_drive;
    assign msg_out.sop   = w_drive & r_first;
    assign msg_out.eop   = w_drive & w_eop;
    assign msg_out.empty = w_drive ? w_empty : '0;
    assign msg_out.data  = w_drive ? w_data : '0;
    assign raw_rdy       = w_send & msg_out.rdy;
    assign busy          = w_send;
    assign len_error     = r_len_error;

    always_ff @(posedge clk or negedge rst) begin
        if (rst == 1'(G_RST_POLARITY)) begin
            r_state     <= IDLE;
            r_remaining <= '0;
            r_first     <= 1'b0;
            r_len_error <= 1'b0;
        end else begin
            r_len_error <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_cmd_hs) begin
                        if (w_cmd_legal) begin
                            r_remaining <= cmd_len;
                            r_first     <= 1'b1;
                            r_state     <= SEND;
                        end else begin
                            r_len_error <= 1'b1;
                        end
                    end
                end
                SEND: begin
                    if (w_xfer) begin
                        r_first <= 1'b0;
                        if (w_eop) begin
                            r_state <= IDLE;
`ifdef AVALON_PACKETIZER_B2B_EN
                            if (w_cmd_hs) begin
                                if (w_cmd_legal) begin
                                    r_remaining <= cmd_len;
                                    r_first     <= 1'b1;
                                    r_state     <= SEND;
                                end else begin
                                    r_len_error <= 1'b1;
                                end
                            end
`endif
                        end else begin
                            r_remaining <= r_remaining - LEN_W'(DATA_WIDTH_IN_BYTES);
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
